// File: rtl/iir_channel_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : iir_channel_scheduler
// Description : Round-robin scheduler that time-multiplexes one shared IIR
//               filter datapath between CHANNELS sample streams. One sample
//               per transaction: IDLE -> ISSUE -> WAIT -> DELIVER -> IDLE.
//               flt_sel selects the filter's per-channel delay-line bank.
// Options     : IIR_SCHED_TIMEOUT_EN - adds a WAIT watchdog and the
//               sched_timeout output; the sample is dropped on expiry.
// Revision    : 1.0 - initial release
// ============================================================================
module iir_channel_scheduler #(
  parameter int CHANNELS       = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int SEL_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [CHANNELS-1:0]            req_valid,
  input  logic [CHANNELS*DATA_WIDTH-1:0] req_data,
  output logic [CHANNELS-1:0]            req_ready,
  output logic                           flt_start,
  output logic [DATA_WIDTH-1:0]          flt_data,
  output logic [SEL_W-1:0]               flt_sel,
  input  logic                           flt_done,
  input  logic [DATA_WIDTH-1:0]          flt_result,
  output logic [CHANNELS-1:0]            out_valid,
  output logic [DATA_WIDTH-1:0]          out_data,
`ifdef IIR_SCHED_TIMEOUT_EN
  output logic                           sched_timeout,
`endif
  output logic                           busy
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_WAIT    = 2'd2;
  localparam logic [1:0] ST_DELIVER = 2'd3;

  // Parameter sanity: the scan arithmetic assumes 2..8 channels.
  if (CHANNELS < 2 || CHANNELS > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("iir_channel_scheduler: CHANNELS must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  logic [1:0]            state;
  logic [SEL_W-1:0]      rr_ptr;
  logic [SEL_W-1:0]      grant_idx;
  logic                  grant_found;
  logic [SEL_W:0]        scan_sum;
  logic [DATA_WIDTH-1:0] grant_data;
  logic [SEL_W-1:0]      next_ptr;
  logic                  wait_expired;

  // Pointer to the channel after the one just served, wrapping at CHANNELS.
  assign next_ptr = (flt_sel == SEL_W'(CHANNELS - 1)) ? '0 : flt_sel + 1'b1;

  // Round-robin search: first valid channel starting at rr_ptr, modulo CHANNELS.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_sum    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      scan_sum = {1'b0, rr_ptr} + (SEL_W + 1)'(i);
      if (scan_sum >= (SEL_W + 1)'(CHANNELS)) begin
        scan_sum = scan_sum - (SEL_W + 1)'(CHANNELS);
      end
      if (!grant_found && req_valid[scan_sum[SEL_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan_sum[SEL_W-1:0];
      end
    end
  end

  // Granted channel's data mux and the one-hot ready, offered in IDLE only.
  // Ready is also held low while reset is asserted so nothing is accepted then.
  always_comb begin
    grant_data = '0;
    req_ready  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (grant_idx == SEL_W'(c)) begin
        grant_data = req_data[c*DATA_WIDTH +: DATA_WIDTH];
      end
      req_ready[c] = reset && (state == ST_IDLE) && grant_found && (grant_idx == SEL_W'(c));
    end
  end

  // Per-channel result strobe, decoded from the owning channel during DELIVER.
  always_comb begin
    out_valid = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      out_valid[c] = (state == ST_DELIVER) && (flt_sel == SEL_W'(c));
    end
  end

  assign flt_start = (state == ST_ISSUE);
  assign busy      = (state != ST_IDLE);

`ifdef IIR_SCHED_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt;

  // Expiry fires on the last allowed WAIT cycle; a done in that cycle wins.
  assign wait_expired = (state == ST_WAIT) && !flt_done && (wait_cnt == WAIT_LAST);

  // WAIT-cycle watchdog: cleared while issuing, counts each WAIT cycle without done.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt      <= '0;
      sched_timeout <= 1'b0;
    end else begin
      sched_timeout <= wait_expired;
      if (state == ST_ISSUE) begin
        wait_cnt <= '0;
      end else if (state == ST_WAIT && !flt_done && wait_cnt != WAIT_LAST) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end
`else
  assign wait_expired = 1'b0;
`endif

  // Transaction FSM plus the registered filter-side and result-side datapath.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      flt_data <= '0;
      flt_sel  <= '0;
      out_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_found) begin
            flt_data <= grant_data;
            flt_sel  <= grant_idx;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (flt_done) begin
            out_data <= flt_result;
            state    <= ST_DELIVER;
          end else if (wait_expired) begin
            // Abort: drop the sample but still move fairness on.
            rr_ptr <= next_ptr;
            state  <= ST_IDLE;
          end
        end
        ST_DELIVER: begin
          rr_ptr <= next_ptr;
          state  <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
